// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: drives a req/resp data-cache port, stalls the pipeline while busy,
// returns extended load data. Latency: done one cycle after dmem_resp; misaligned done in cycle 1.
module mem_access_unit #(
    parameter int MAX_WAIT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        timeout,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_byte_enable,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp
);
    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] LAST = CW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]  r_addr_lo;
    logic [2:0]  r_funct3;
    logic        r_is_read;
    logic        r_done, r_misaligned, r_timeout;
    logic        r_dmem_read, r_dmem_write;
    logic [31:0] r_dmem_address, r_dmem_wdata, r_load_data;
    logic [3:0]  r_dmem_be;

    logic        w_req, w_mis, w_expire;
    logic [1:0]  w_size;
    logic [3:0]  w_be;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    assign w_req  = req_read | req_write;
    assign w_size = req_funct3[1:0];
    // funct3[1:0]==3 behaves as a word access throughout
    assign w_mis  = ((w_size == 2'd1) & req_addr[0]) | (w_size[1] & (|req_addr[1:0]));
    assign w_expire = (MAX_WAIT != 0) && (r_cnt == LAST);

    always_comb begin
        w_be = 4'b1111;
        case (w_size)
            2'd0:    w_be = 4'b0001 << req_addr[1:0];
            2'd1:    w_be = 4'b0011 << {req_addr[1], 1'b0};
            default: w_be = 4'b1111;
        endcase
    end

    assign w_byte = 8'(dmem_rdata >> {r_addr_lo, 3'b000});
    assign w_half = 16'(dmem_rdata >> {r_addr_lo[1], 4'b0000});

    always_comb begin
        w_load = dmem_rdata;
        case (r_funct3)
            3'd0:    w_load = {{24{w_byte[7]}}, w_byte};
            3'd4:    w_load = {24'd0, w_byte};
            3'd1:    w_load = {{16{w_half[15]}}, w_half};
            3'd5:    w_load = {16'd0, w_half};
            default: w_load = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_addr_lo      <= '0;
            r_funct3       <= '0;
            r_is_read      <= 1'b0;
            r_done         <= 1'b0;
            r_misaligned   <= 1'b0;
            r_timeout      <= 1'b0;
            r_dmem_read    <= 1'b0;
            r_dmem_write   <= 1'b0;
            r_dmem_address <= '0;
            r_dmem_wdata   <= '0;
            r_dmem_be      <= '0;
            r_load_data    <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_req) begin
                    r_addr_lo <= req_addr[1:0];
                    r_funct3  <= req_funct3;
                    r_is_read <= req_read;
                    if (w_mis) begin
                        r_state      <= S_DONE;
                        r_done       <= 1'b1;
                        r_misaligned <= 1'b1;
                        r_load_data  <= '0;
                    end else begin
                        r_state        <= S_BUSY;
                        r_cnt          <= '0;
                        r_dmem_read    <= req_read;
                        r_dmem_write   <= ~req_read;
                        r_dmem_address <= {req_addr[31:2], 2'b00};
                        r_dmem_wdata   <= req_wdata << {req_addr[1:0], 3'b000};
                        r_dmem_be      <= w_be;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (dmem_resp) begin
                        r_state      <= S_DONE;
                        r_done       <= 1'b1;
                        r_dmem_read  <= 1'b0;
                        r_dmem_write <= 1'b0;
                        r_load_data  <= r_is_read ? w_load : 32'd0;
                    end else if (w_expire) begin
                        r_state      <= S_DONE;
                        r_done       <= 1'b1;
                        r_timeout    <= 1'b1;
                        r_dmem_read  <= 1'b0;
                        r_dmem_write <= 1'b0;
                        r_load_data  <= '0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_done       <= 1'b0;
                    r_misaligned <= 1'b0;
                    r_timeout    <= 1'b0;
                    r_load_data  <= '0;
                end
            endcase
        end
    end

    // reset is folded in so stall also reads 0 while rst is held low
    assign stall            = rst & (((r_state == S_IDLE) & w_req) | (r_state == S_BUSY));
    assign done             = r_done;
    assign misaligned       = r_misaligned;
    assign timeout          = r_timeout;
    assign load_data        = r_load_data;
    assign dmem_read        = r_dmem_read;
    assign dmem_write       = r_dmem_write;
    assign dmem_address     = r_dmem_address;
    assign dmem_wdata       = r_dmem_wdata;
    assign dmem_byte_enable = r_dmem_be;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus randomized accesses against a byte-lane reference model.
module tb_mem_access_unit;
    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_read, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        stall, done, misaligned, timeout;
    logic [31:0] load_data;
    logic        dmem_read, dmem_write;
    logic [31:0] dmem_address, dmem_wdata;
    logic [3:0]  dmem_byte_enable;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;

    int n_vec = 0;
    int n_err = 0;

    mem_access_unit #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .req_read(req_read), .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .done(done), .load_data(load_data),
        .misaligned(misaligned), .timeout(timeout),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
        .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int acc_bytes(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a);
        return (a % acc_bytes(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int n;
        n = acc_bytes(f3);
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] wd, input logic [31:0] a);
        return wd << (8 * (a % 4));
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int n;
        logic [31:0] mask, v;
        n = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        v = (rd >> (8 * (a % 4))) & mask;
        if (n < 4 && f3[2] == 1'b0 && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- driver: runs one access and records what the DUT did ----------------
    int          obs_done_cyc, obs_req_cyc;
    logic        obs_stall0, obs_busy_stall, obs_stable, obs_rd, obs_wr;
    logic [31:0] obs_addr, obs_wdata, obs_load;
    logic [3:0]  obs_be;
    logic        obs_mis, obs_to, obs_done_stall, obs_done_req, obs_idle;

    task automatic drive_access(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] rdat, input int resp_at);
        req_read = rd; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        #1;
        obs_stall0 = stall;
        obs_done_cyc = -1; obs_req_cyc = 0; obs_busy_stall = 1'b1; obs_stable = 1'b1;
        obs_rd = 1'b0; obs_wr = 1'b0; obs_addr = '0; obs_be = '0; obs_wdata = '0;
        obs_load = '0; obs_mis = 1'b0; obs_to = 1'b0; obs_done_stall = 1'b1; obs_done_req = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            dmem_resp = 1'b0;
            if (done) begin
                obs_done_cyc = c; obs_load = load_data; obs_mis = misaligned; obs_to = timeout;
                obs_done_stall = stall; obs_done_req = dmem_read | dmem_write;
                break;
            end
            obs_busy_stall = obs_busy_stall & stall;
            if (dmem_read || dmem_write) begin
                if (obs_req_cyc == 0) begin
                    obs_rd = dmem_read; obs_wr = dmem_write; obs_addr = dmem_address;
                    obs_be = dmem_byte_enable; obs_wdata = dmem_wdata;
                end else if ({dmem_read, dmem_write, dmem_address, dmem_byte_enable, dmem_wdata}
                             != {obs_rd, obs_wr, obs_addr, obs_be, obs_wdata}) begin
                    obs_stable = 1'b0;
                end
                obs_req_cyc++;
            end
            if (c == resp_at) begin dmem_resp = 1'b1; dmem_rdata = rdat; end
            else dmem_rdata = $urandom;
        end
        @(posedge clk); #1;
        req_read = 1'b0; req_write = 1'b0;
        #1;
        obs_idle = !done && !stall && !dmem_read && !dmem_write;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0; req_read = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
        req_wdata = '0; dmem_rdata = '0; dmem_resp = 1'b0;
        #3;
        n_vec++;
        if ({stall, done, misaligned, timeout, dmem_read, dmem_write, load_data, dmem_address,
             dmem_wdata, dmem_byte_enable} !== '0) begin
            n_err++; $display("FAIL reset_outputs got stall=%b done=%b rd=%b wr=%b addr=%h be=%b exp all zero",
                              stall, done, dmem_read, dmem_write, dmem_address, dmem_byte_enable);
        end
        req_read = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if ({stall, done, dmem_read, dmem_write} !== 4'b0) begin
            n_err++; $display("FAIL reset_release_idle got %b exp 0000", {stall, done, dmem_read, dmem_write});
        end
    endtask

    task automatic test_lw();
        drive_access(1'b1, 1'b0, 3'd2, 32'h1000, 32'h0, 32'hDEAD_BEEF, 3);
        n_vec++; if (obs_done_cyc !== 4) begin n_err++; $display("FAIL lw_done_cycle got %0d exp 4", obs_done_cyc); end
        n_vec++; if (obs_load !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL lw_load got %h exp deadbeef", obs_load); end
        n_vec++; if (obs_req_cyc !== 3 || obs_rd !== 1'b1 || obs_wr !== 1'b0) begin
            n_err++; $display("FAIL lw_read_cycles got %0d rd=%b wr=%b exp 3 1 0", obs_req_cyc, obs_rd, obs_wr); end
        n_vec++; if (obs_addr !== 32'h1000 || obs_be !== 4'b1111 || !obs_stable) begin
            n_err++; $display("FAIL lw_port got addr=%h be=%b stable=%b exp 1000 1111 1", obs_addr, obs_be, obs_stable); end
        n_vec++; if ({obs_stall0, obs_busy_stall, obs_done_stall} !== 3'b110) begin
            n_err++; $display("FAIL lw_stall got %b exp 110", {obs_stall0, obs_busy_stall, obs_done_stall}); end
        n_vec++; if (!obs_idle) begin n_err++; $display("FAIL lw_idle_after got 0 exp 1"); end
    endtask

    task automatic test_byte_half();
        drive_access(1'b1, 1'b0, 3'd0, 32'h2003, 32'h0, 32'h80FF_1234, 1);
        n_vec++; if (obs_be !== 4'b1000 || obs_load !== 32'hFFFF_FF80) begin
            n_err++; $display("FAIL lb got be=%b load=%h exp 1000 ffffff80", obs_be, obs_load); end
        drive_access(1'b1, 1'b0, 3'd4, 32'h2003, 32'h0, 32'h80FF_1234, 2);
        n_vec++; if (obs_load !== 32'h0000_0080) begin n_err++; $display("FAIL lbu got %h exp 00000080", obs_load); end
        drive_access(1'b1, 1'b0, 3'd1, 32'h2002, 32'h0, 32'h80FF_1234, 1);
        n_vec++; if (obs_be !== 4'b1100 || obs_load !== 32'hFFFF_80FF) begin
            n_err++; $display("FAIL lh got be=%b load=%h exp 1100 ffff80ff", obs_be, obs_load); end
    endtask

    task automatic test_store();
        drive_access(1'b0, 1'b1, 3'd1, 32'h3002, 32'h0000_ABCD, 32'h1234_5678, 2);
        n_vec++; if (obs_wr !== 1'b1 || obs_rd !== 1'b0 || obs_addr !== 32'h3000) begin
            n_err++; $display("FAIL sh_port got wr=%b rd=%b addr=%h exp 1 0 3000", obs_wr, obs_rd, obs_addr); end
        n_vec++; if (obs_be !== 4'b1100 || obs_wdata !== 32'hABCD_0000) begin
            n_err++; $display("FAIL sh_data got be=%b wdata=%h exp 1100 abcd0000", obs_be, obs_wdata); end
        n_vec++; if (obs_done_cyc !== 3 || obs_load !== 32'h0) begin
            n_err++; $display("FAIL sh_done got cyc=%0d load=%h exp 3 0", obs_done_cyc, obs_load); end
    endtask

    task automatic test_misaligned();
        drive_access(1'b1, 1'b0, 3'd2, 32'h4001, 32'h0, 32'hFFFF_FFFF, 1);
        n_vec++; if (obs_done_cyc !== 1 || obs_mis !== 1'b1 || obs_to !== 1'b0) begin
            n_err++; $display("FAIL lw_misaligned got cyc=%0d mis=%b to=%b exp 1 1 0", obs_done_cyc, obs_mis, obs_to); end
        n_vec++; if (obs_req_cyc !== 0 || obs_done_req !== 1'b0 || obs_load !== 32'h0) begin
            n_err++; $display("FAIL misaligned_no_access got req_cycles=%0d load=%h exp 0 0", obs_req_cyc, obs_load); end
        n_vec++; if ({obs_stall0, obs_done_stall} !== 2'b10) begin
            n_err++; $display("FAIL misaligned_stall got %b exp 10", {obs_stall0, obs_done_stall}); end
    endtask

    task automatic test_timeout();
        drive_access(1'b1, 1'b0, 3'd2, 32'h5000, 32'h0, 32'h0, 0);
        n_vec++; if (obs_req_cyc !== MW || obs_done_cyc !== MW + 1) begin
            n_err++; $display("FAIL timeout_len got req=%0d done=%0d exp %0d %0d", obs_req_cyc, obs_done_cyc, MW, MW + 1); end
        n_vec++; if (obs_to !== 1'b1 || obs_mis !== 1'b0 || obs_load !== 32'h0 || obs_done_req !== 1'b0) begin
            n_err++; $display("FAIL timeout_flags got to=%b mis=%b load=%h req=%b exp 1 0 0 0", obs_to, obs_mis, obs_load, obs_done_req); end
        dmem_resp = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1; dmem_resp = 1'b0;
        @(posedge clk); #1;
        n_vec++; if ({done, stall, dmem_read, dmem_write, timeout} !== 5'b0) begin
            n_err++; $display("FAIL stray_resp got %b exp 00000", {done, stall, dmem_read, dmem_write, timeout}); end
        // resp on the final allowed cycle beats expiry
        drive_access(1'b1, 1'b0, 3'd2, 32'h5004, 32'h0, 32'h1357_9BDF, MW);
        n_vec++; if (obs_to !== 1'b0 || obs_load !== 32'h1357_9BDF || obs_done_cyc !== MW + 1) begin
            n_err++; $display("FAIL resp_wins got to=%b load=%h cyc=%0d exp 0 13579bdf %0d", obs_to, obs_load, obs_done_cyc, MW + 1); end
    endtask

    task automatic test_reset_mid_busy();
        req_read = 1'b0; req_write = 1'b1; req_funct3 = 3'd2; req_addr = 32'h6000; req_wdata = 32'h1111_2222;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_vec++; if (dmem_write !== 1'b1) begin n_err++; $display("FAIL sw_busy got dmem_write=%b exp 1", dmem_write); end
        #2 rst = 1'b0;
        #1;
        n_vec++; if ({dmem_write, dmem_read, stall, done} !== 4'b0) begin
            n_err++; $display("FAIL async_reset_drop got %b exp 0000", {dmem_write, dmem_read, stall, done}); end
        req_write = 1'b0;
        @(posedge clk); #2 rst = 1'b1;
        dmem_resp = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1; dmem_resp = 1'b0;
        n_vec++;
        if ({stall, done, misaligned, timeout, dmem_read, dmem_write, load_data, dmem_address,
             dmem_wdata, dmem_byte_enable} !== '0) begin
            n_err++; $display("FAIL post_reset_idle got stall=%b done=%b rd=%b wr=%b load=%h be=%b exp all zero",
                              stall, done, dmem_read, dmem_write, load_data, dmem_byte_enable);
        end
        drive_access(1'b0, 1'b1, 3'd2, 32'h6000, 32'h1111_2222, 32'h0, 1);
        n_vec++; if (obs_done_cyc !== 2 || obs_wdata !== 32'h1111_2222 || obs_be !== 4'b1111) begin
            n_err++; $display("FAIL post_reset_sw got cyc=%0d wdata=%h be=%b exp 2 11112222 1111", obs_done_cyc, obs_wdata, obs_be); end
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, wd, rd;
        logic        r, w, mis, is_rd;
        int          at, exp_cyc;
        for (int i = 0; i < 60; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a = $urandom; wd = $urandom; rd = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            r = 1'($urandom_range(0, 1));
            w = r ? 1'($urandom_range(0, 1)) : 1'b1;
            at = $urandom_range(1, MW);
            is_rd = r;
            mis = m_mis(f3, a);
            exp_cyc = mis ? 1 : at + 1;
            drive_access(r, w, f3, a, wd, rd, at);
            n_vec++; if (obs_done_cyc !== exp_cyc || obs_mis !== mis || obs_to !== 1'b0) begin
                n_err++; $display("FAIL rnd_done i=%0d f3=%0d a=%h got cyc=%0d mis=%b to=%b exp %0d %b 0",
                                  i, f3, a, obs_done_cyc, obs_mis, obs_to, exp_cyc, mis); end
            n_vec++; if (obs_load !== ((is_rd && !mis) ? m_load(f3, a, rd) : 32'h0)) begin
                n_err++; $display("FAIL rnd_load i=%0d f3=%0d a=%h rd=%h got %h exp %h", i, f3, a, rd, obs_load,
                                  (is_rd && !mis) ? m_load(f3, a, rd) : 32'h0); end
            if (!mis) begin
                n_vec++; if (obs_rd !== is_rd || obs_wr !== !is_rd || obs_req_cyc !== at || !obs_stable) begin
                    n_err++; $display("FAIL rnd_req i=%0d got rd=%b wr=%b cycles=%0d stable=%b exp %b %b %0d 1",
                                      i, obs_rd, obs_wr, obs_req_cyc, obs_stable, is_rd, !is_rd, at); end
                n_vec++; if (obs_addr !== {a[31:2], 2'b00} || obs_be !== m_be(f3, a)) begin
                    n_err++; $display("FAIL rnd_port i=%0d f3=%0d a=%h got addr=%h be=%b exp %h %b",
                                      i, f3, a, obs_addr, obs_be, {a[31:2], 2'b00}, m_be(f3, a)); end
                if (!is_rd) begin
                    n_vec++; if (obs_wdata !== m_wdata(wd, a)) begin
                        n_err++; $display("FAIL rnd_wdata i=%0d a=%h got %h exp %h", i, a, obs_wdata, m_wdata(wd, a)); end
                end
            end
            n_vec++; if ({obs_stall0, obs_busy_stall, obs_done_stall, obs_idle} !== 4'b1101) begin
                n_err++; $display("FAIL rnd_stall i=%0d got %b exp 1101", i, {obs_stall0, obs_busy_stall, obs_done_stall, obs_idle}); end
        end
    endtask

    task automatic test_back_to_back();
        drive_access(1'b1, 1'b1, 3'd5, 32'h7006, 32'hFFFF_FFFF, 32'h8001_0000, 1);
        n_vec++; if (obs_rd !== 1'b1 || obs_wr !== 1'b0 || obs_load !== 32'h0000_8001) begin
            n_err++; $display("FAIL b2b_lhu got rd=%b wr=%b load=%h exp 1 0 00008001", obs_rd, obs_wr, obs_load); end
        drive_access(1'b0, 1'b1, 3'd0, 32'h7001, 32'h0000_00A5, 32'h0, 1);
        n_vec++; if (obs_be !== 4'b0010 || obs_wdata !== 32'h0000_A500 || obs_done_cyc !== 2) begin
            n_err++; $display("FAIL b2b_sb got be=%b wdata=%h cyc=%0d exp 0010 0000a500 2", obs_be, obs_wdata, obs_done_cyc); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_byte_half();
        test_store();
        test_misaligned();
        test_timeout();
        test_reset_mid_busy();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store engine.
- Consumes the decoded memory request from the control word (dmem_read, dmem_write, funct3), plus the ALU effective address and rs2 data.
- Drives the data-cache port with a req/resp handshake and stalls the pipeline while the access is outstanding.
- Returns aligned, sign/zero-extended load data for the regfile write-back mux.

Parameters:
- MAX_WAIT, 1023: max cycles spent in BUSY before the access aborts with timeout; 0 disables the timeout.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req_read  in  1  load request (ctrl.dmem_read of the MEM-stage instruction)
- req_write  in  1  store request (ctrl.dmem_write)
- req_funct3  in  3  load/store funct3
- req_addr  in  32  effective byte address (alu_out)
- req_wdata  in  32  store data (rs2_out), unshifted
- stall  out  1  hold all pipeline registers
- done  out  1  one-cycle completion pulse
- load_data  out  32  extended load result; valid only while done=1
- misaligned  out  1  completion was a misaligned-address abort; valid with done
- timeout  out  1  completion was a MAX_WAIT abort; valid with done
- dmem_read  out  1  cache read request
- dmem_write  out  1  cache write request
- dmem_address  out  32  word-aligned address ({req_addr[31:2],2'b00})
- dmem_wdata  out  32  store data, shifted into byte lanes
- dmem_byte_enable  out  4  lane mask for reads and writes
- dmem_rdata  in  32  cache read word
- dmem_resp  in  1  cache completion, one cycle

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE.
  - All outputs read 0: dmem_read/dmem_write drop immediately, even mid-BUSY.
  - The wait counter clears.
  - A dmem_resp arriving after reset release is ignored.
- States are IDLE, BUSY, DONE.
- IDLE:
  - Request present = req_read | req_write.
  - If both are set, the access is a read and req_write is ignored.
  - stall = request present, combinationally.
  - On a request, latch addr, funct3, wdata and the read/write type.
  - Aligned request → BUSY.
  - Misaligned request → DONE with misaligned=1 and no cache access issued.
    - Word access (funct3[1:0]=2): misaligned if addr[1:0]≠0.
    - Half access (funct3[1:0]=1): misaligned if addr[0]≠0.
- BUSY:
  - dmem_read or dmem_write=1, with address, wdata and byte_enable registered and held stable.
  - stall=1.
  - The wait counter increments each cycle.
  - Cycle with dmem_resp=1 → capture dmem_rdata and go to DONE.
  - Counter reaches MAX_WAIT with no resp → deassert the request and go to DONE with timeout=1.
  - If resp and expiry coincide, resp wins.
- DONE (exactly 1 cycle):
  - done=1, stall=0; the pipeline advances on this edge.
  - Request inputs are ignored; they still show the finishing instruction.
  - Next state is always IDLE.
- Latency:
  - Aligned access: request seen in cycle 0, BUSY from cycle 1, resp in cycle N≥1, done in cycle N+1.
  - Misaligned access: done in cycle 1.
- Byte enable, by funct3[1:0]:
  - Word (2): 4'b1111.
  - Half (1): 4'b0011 << addr[1]*2.
  - Byte (0): 4'b0001 << addr[1:0].
  - Value 3: treated as word.
- Store data:
  - dmem_wdata = req_wdata << (8*addr[1:0]).
  - Unused lanes are don't-care but are driven deterministically from the shift.
- Load extraction: byte = rdata >> 8*addr[1:0], half = rdata >> 16*addr[1].
  - lb: sign-extend byte.
  - lbu: zero-extend byte.
  - lh: sign-extend half.
  - lhu: zero-extend half.
  - lw: full word.
  - Undefined funct3 (3, 6, 7): treated as lw.
- Stores: load_data=0 at done. Any abort also gives load_data=0.
- dmem_resp outside BUSY is ignored.

Test Plan:
- lw, addr 0x1000, cache resp after 3 BUSY cycles with rdata 0xDEADBEEF:
  - dmem_read=1, address 0x1000, byte_enable 1111 for 3 cycles.
  - done at cycle 4 with load_data 0xDEADBEEF.
  - stall high in cycles 0-3, low in 4.
- lb and lbu at addr 0x2003, rdata 0x80FF1234:
  - lb gives byte_enable 1000 and load_data 0xFFFFFF80.
  - lbu gives 0x00000080.
  - lh at 0x2002 gives 0xFFFF80FF.
- sh, addr 0x3002, wdata 0x0000ABCD:
  - dmem_write=1, address 0x3000, byte_enable 1100, wdata 0xABCD0000.
  - done the cycle after resp, with load_data 0.
- lw at 0x4001:
  - No dmem_read is ever asserted.
  - done and misaligned=1 in cycle 1, stall=1 in cycle 0 only.
- MAX_WAIT=4, no resp:
  - dmem_read held 4 cycles, then dropped.
  - done with timeout=1.
  - A later stray resp is ignored and the unit returns to IDLE.
- rst pulled low in the 2nd BUSY cycle of a sw:
  - dmem_write drops asynchronously before the next edge.
  - After rst release, IDLE with all outputs 0.
  - A back-to-back request is then accepted normally.
